// File: rtl/vdp_wrq_pkg.sv
// Shared types and default sizing for the VRAM write scheduler and its FIFO.
// The entry struct here is the default FIFO element type at the default address width.
package vdp_wrq_pkg;

  localparam int WRQ_DEPTH  = 4;
  localparam int WRQ_ADDR_W = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } wrq_state_t;

  typedef struct packed {
    logic [WRQ_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } wrq_entry_t;

endpackage

// File: rtl/vram_wrq_fifo.sv
// Write-queue storage: DEPTH entries with wrapping pointers, occupancy count and flags.
// The head entry is presented combinationally; clear empties the queue on the next edge.
module vram_wrq_fifo
  import vdp_wrq_pkg::*;
#(
  parameter int  DEPTH   = WRQ_DEPTH,
  parameter type entry_t = wrq_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  entry_t                   wr_entry,
  output entry_t                   rd_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;
  assign rd_entry = mem[rd_ptr];

  // Storage carries no reset; only the pointers define which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Queues CPU VRAM writes and issues them one at a time over a toggle req/ack handshake.
// Define VRAM_WRQ_STATS_EN to build the stall_count cycle counter; otherwise it reads 0.
module vram_write_scheduler
  import vdp_wrq_pkg::*;
#(
  parameter int DEPTH  = WRQ_DEPTH,
  parameter int ADDR_W = WRQ_ADDR_W
) (
  input  logic              CLK21M,
  input  logic              RESET,
  input  logic              cpu_wr_valid,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [7:0]        cpu_wr_data,
  output logic              cpu_wr_ready,
  input  logic              flush,
  output logic              vram_wr_req,
  input  logic              vram_wr_ack,
  output logic [ADDR_W-1:0] vram_wr_addr,
  output logic [7:0]        vram_wr_data,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       stall_count,
  output wrq_state_t        fsm_state
);

  // Handshake: a request is pending while vram_wr_req != vram_wr_ack. Issuing a
  // write toggles vram_wr_req; the arbiter completes it by copying req onto ack.
  // Address/data are loaded on the issuing edge and held until the next issue.

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wrq_state_t       state;
  entry_t           push_entry;
  entry_t           head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             pending;
  logic             push;
  logic             pop;

  assign push_entry   = '{addr: cpu_wr_addr, data: cpu_wr_data};
  assign cpu_wr_ready = !full;
  assign pending      = (vram_wr_req != vram_wr_ack);
  assign push         = cpu_wr_valid && !flush;
  // A flush cycle never issues: every entry still queued is discarded instead.
  assign pop          = !flush && !empty &&
                        ((state == ISSUE) || ((state == WAIT) && !pending));
  assign busy         = (count != '0) || (state != IDLE);
  assign fsm_state    = state;

  vram_wrq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (CLK21M),
    .rst      (RESET),
    .push     (push),
    .pop      (pop),
    .clear    (flush),
    .wr_entry (push_entry),
    .rd_entry (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      vram_wr_req  <= 1'b0;
      vram_wr_addr <= '1;
      vram_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty && !flush) begin
            state <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (pop) begin
            vram_wr_addr <= head.addr;
            vram_wr_data <= head.data;
            vram_wr_req  <= ~vram_wr_req;
            state        <= WAIT;
          end else if ((state == ISSUE) || !pending) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (cpu_wr_valid && full) begin
      overflow <= 1'b1;
    end
  end

`ifdef VRAM_WRQ_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if ((state == WAIT) && pending && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: a toggle-handshake arbiter model pops an
// expected-write queue on every issued request and checks address/data order.
module tb_vram_write_scheduler;
  import vdp_wrq_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 19;
  localparam int E_W    = ADDR_W + 8;

  logic              CLK21M = 1'b0;
  logic              RESET  = 1'b0;
  logic              cpu_wr_valid = 1'b0;
  logic [ADDR_W-1:0] cpu_wr_addr  = '0;
  logic [7:0]        cpu_wr_data  = '0;
  logic              cpu_wr_ready;
  logic              flush = 1'b0;
  logic              vram_wr_req;
  logic              vram_wr_ack = 1'b0;
  logic [ADDR_W-1:0] vram_wr_addr;
  logic [7:0]        vram_wr_data;
  logic              busy;
  logic              overflow;
  logic [15:0]       stall_count;
  wrq_state_t        fsm_state;

  vram_write_scheduler #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK21M       (CLK21M),
    .RESET        (RESET),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ready (cpu_wr_ready),
    .flush        (flush),
    .vram_wr_req  (vram_wr_req),
    .vram_wr_ack  (vram_wr_ack),
    .vram_wr_addr (vram_wr_addr),
    .vram_wr_data (vram_wr_data),
    .busy         (busy),
    .overflow     (overflow),
    .stall_count  (stall_count),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK21M = ~CLK21M;

  int cyc = 0;
  always @(posedge CLK21M) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [E_W-1:0] exp_q[$];
  int tcyc[$];
  int toggles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- arbiter model ----------------
  logic              seen_req  = 1'b0;
  bit                pend      = 1'b0;
  int                ack_cnt   = 0;
  int                ack_delay = 0;
  bit                ack_hold  = 1'b0;
  logic [ADDR_W-1:0] held_addr = '0;
  logic [7:0]        held_data = '0;
  logic [E_W-1:0]    exp_e;

  always @(negedge CLK21M) begin
    if (!RESET) begin
      if (vram_wr_req !== seen_req) begin
        seen_req = vram_wr_req;
        toggles++;
        tcyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("spurious_issue", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("issue_addr", 32'(vram_wr_addr), 32'(exp_e[E_W-1:8]));
          check("issue_data", 32'(vram_wr_data), 32'(exp_e[7:0]));
        end
        held_addr = vram_wr_addr;
        held_data = vram_wr_data;
        pend      = 1'b1;
        ack_cnt   = ack_delay;
      end else if (pend) begin
        check("hold_addr", 32'(vram_wr_addr), 32'(held_addr));
        check("hold_data", 32'(vram_wr_data), 32'(held_data));
        if (ack_cnt > 0) ack_cnt--;
      end
      if (pend && (ack_cnt == 0) && !ack_hold) begin
        vram_wr_ack = vram_wr_req;
        pend        = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK21M);
    #1;
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit expect_issue);
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = a;
    cpu_wr_data  = d;
    if (expect_issue) exp_q.push_back({a, d});
    tick();
    cpu_wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0) && (n < 60)) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      32'(vram_wr_req),  32'd0);
    check({tag, "_addr"},     32'(vram_wr_addr), 32'h7FFFF);
    check({tag, "_data"},     32'(vram_wr_data), 32'd0);
    check({tag, "_ready"},    32'(cpu_wr_ready), 32'd1);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_overflow"}, 32'(overflow),     32'd0);
    check({tag, "_stall"},    32'(stall_count),  32'd0);
    check({tag, "_state"},    32'(fsm_state),    32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  int base_t;
  int base_n;

  initial begin
    // Reset state
    #2 RESET = 1'b1;
    #1 check_reset_outputs("reset");
    tick();
    tick();
    RESET = 1'b0;
    tick();

    // Single write, ack 3 cycles after the request
    ack_delay = 3;
    base_t    = toggles;
    push_word(19'h1_2345, 8'hA5, 1'b1);
    check("single_busy_after_push", 32'(busy), 32'd1);
    check("single_req_n1", 32'(vram_wr_req), 32'd0);
    tick();
    check("single_state_n1", 32'(fsm_state), 32'(ISSUE));
    check("single_req_n1b", 32'(vram_wr_req), 32'd0);
    tick();
    check("single_req_n2", 32'(vram_wr_req), 32'd1);
    check("single_addr_n2", 32'(vram_wr_addr), 32'h1_2345);
    check("single_data_n2", 32'(vram_wr_data), 32'hA5);
    check("single_state_n2", 32'(fsm_state), 32'(WAIT));
    tick();
    tick();
    tick();
    check("single_busy_at_ack", 32'(busy), 32'd1);
    tick();
    check("single_busy_fall", 32'(busy), 32'd0);
    check("single_state_idle", 32'(fsm_state), 32'(IDLE));
`ifdef VRAM_WRQ_STATS_EN
    check("single_stall", 32'(stall_count), 32'd3);
`else
    check("single_stall", 32'(stall_count), 32'd0);
`endif
    check("single_toggles", 32'(toggles - base_t), 32'd1);

    // Fill and overflow with the ack held back behind an in-flight write
    ack_hold  = 1'b1;
    ack_delay = 0;
    base_t    = toggles;
    push_word(19'h0_0100, 8'hEE, 1'b1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      check("fill_ready_before", 32'(cpu_wr_ready), 32'd1);
      push_word(19'h0_0200 + 19'(i), 8'(i), 1'b1);
    end
    check("fill_ready_full", 32'(cpu_wr_ready), 32'd0);
    check("fill_overflow_pre", 32'(overflow), 32'd0);
    push_word(19'h0_0205, 8'h05, 1'b0);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_ready_still", 32'(cpu_wr_ready), 32'd0);
    check("fill_one_issued", 32'(toggles - base_t), 32'd1);
    ack_hold = 1'b0;
    wait_idle("fill_drain");
    check("fill_total_issued", 32'(toggles - base_t), 32'd5);
    check("fill_queue_empty", 32'(exp_q.size()), 32'd0);
    check("fill_overflow_sticky", 32'(overflow), 32'd1);

    // Back-to-back issue: four entries queued behind a held write, ack every cycle
    ack_hold = 1'b1;
    base_t   = toggles;
    push_word(19'h0_0300, 8'hDD, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      push_word(19'h1_0000 + 19'(i), 8'hA0 + 8'(i), 1'b1);
    end
    check("b2b_full", 32'(cpu_wr_ready), 32'd0);
    ack_hold = 1'b0;
    wait_idle("b2b_drain");
    check("b2b_total_issued", 32'(toggles - base_t), 32'd5);
    base_n = tcyc.size();
    for (int k = base_n - 3; k < base_n; k++) begin
      check("b2b_gap", 32'(tcyc[k] - tcyc[k-1]), 32'd1);
    end

    // Flush while WAIT: in-flight write completes, two queued writes discarded
    ack_hold  = 1'b1;
    ack_delay = 2;
    base_t    = toggles;
    push_word(19'h2_0001, 8'hB1, 1'b1);
    push_word(19'h2_0002, 8'hB2, 1'b0);
    push_word(19'h2_0003, 8'hB3, 1'b0);
    check("flush_state_wait", 32'(fsm_state), 32'(WAIT));
    flush        = 1'b1;
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = 19'h0_0007;
    cpu_wr_data  = 8'hCC;
    tick();
    flush        = 1'b0;
    cpu_wr_valid = 1'b0;
    check("flush_overflow_clr", 32'(overflow), 32'd0);
    check("flush_ready", 32'(cpu_wr_ready), 32'd1);
    check("flush_busy_inflight", 32'(busy), 32'd1);
    check("flush_stall_clr", 32'(stall_count), 32'd0);
    ack_hold = 1'b0;
    wait_idle("flush_drain");
    check("flush_state_idle", 32'(fsm_state), 32'(IDLE));
    repeat (8) tick();
    check("flush_issued_once", 32'(toggles - base_t), 32'd1);
    check("flush_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-transfer with two entries queued
    ack_hold  = 1'b1;
    ack_delay = 1;
    push_word(19'h3_0001, 8'hC1, 1'b1);
    push_word(19'h3_0002, 8'hC2, 1'b0);
    push_word(19'h3_0003, 8'hC3, 1'b0);
    check("rst_state_wait", 32'(fsm_state), 32'(WAIT));
    check("rst_req_pending", 32'(vram_wr_req != vram_wr_ack), 32'd1);
    RESET       = 1'b1;
    vram_wr_ack = 1'b0;
    seen_req    = 1'b0;
    pend        = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("midrst");
    tick();
    tick();
    RESET    = 1'b0;
    ack_hold = 1'b0;
    base_t   = toggles;
    repeat (10) tick();
    check("midrst_no_toggle", 32'(toggles - base_t), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    push_word(19'h4_5678, 8'h3C, 1'b1);
    wait_idle("midrst_new_push");
    check("midrst_one_toggle", 32'(toggles - base_t), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_write_scheduler.md
VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: write-queue entries; a power of two, 2..16.
REQ-002 Parameter ADDR_W, default 19: VRAM address width.
REQ-003 CLK21M  in  1  the single clock; every register is updated on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 cpu_wr_valid  in  1  one-cycle pulse: push {cpu_wr_addr, cpu_wr_data}.
REQ-006 cpu_wr_addr  in  ADDR_W  VRAM byte address of the write.
REQ-007 cpu_wr_data  in  8  write data.
REQ-008 cpu_wr_ready  out  1  queue not full (combinational from the count).
REQ-009 flush  in  1  one-cycle pulse: discard every queued entry that is not yet issued.
REQ-010 vram_wr_req  out  1  toggle request to the VRAM access arbiter; a request is pending while vram_wr_req != vram_wr_ack.
REQ-011 vram_wr_ack  in  1  toggle acknowledge from the arbiter.
REQ-012 vram_wr_addr  out  ADDR_W  registered address of the issued write.
REQ-013 vram_wr_data  out  8  registered data of the issued write.
REQ-014 busy  out  1  high while the queue is non-empty or state != IDLE; the CPU read path stalls reads on it.
REQ-015 overflow  out  1  sticky: a push was attempted while the queue was full.
REQ-016 stall_count  out  16  count of cycles spent in WAIT (see Configuration).

Function
REQ-017 Storage: FIFO of DEPTH entries, each {addr, data}; read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
REQ-018 Push when cpu_wr_valid && cpu_wr_ready; push when full is dropped, FIFO unchanged, overflow set.
REQ-019 FSM states are IDLE, ISSUE and WAIT.
REQ-020 IDLE -> ISSUE when count != 0.
REQ-021 ISSUE pops the head into vram_wr_addr/vram_wr_data, toggles vram_wr_req, then goes to WAIT, all in one edge.
REQ-022 WAIT holds while vram_wr_req != vram_wr_ack.
REQ-023 When WAIT sees vram_wr_ack == vram_wr_req:
- count != 0: pop and toggle vram_wr_req on the same edge (back-to-back issue), staying in WAIT.
- count == 0: go to IDLE.
REQ-024 Latency: a push into an empty queue at edge N, with the FSM in IDLE, gives a vram_wr_req toggle at edge N+2.
REQ-025 Simultaneous push and pop in one cycle: count unchanged. When full, the push is still refused, since cpu_wr_ready is low that cycle.
REQ-026 vram_wr_addr/vram_wr_data change only on a pop edge and stay stable while a request is pending.
REQ-027 Writes are issued strictly in push order; there is at most one outstanding request.
REQ-028 Flush:
- Pointers and count are cleared on the next edge.
- An in-flight request in WAIT still completes; the FSM then returns to IDLE.
- A push in the same cycle as flush is discarded.
- overflow is cleared.
REQ-029 busy is registered-equivalent: it is low only when count == 0 and state == IDLE.

Reset
REQ-030 RESET forces these values immediately, even mid-transfer:
- state = IDLE; pointers and count = 0.
- vram_wr_req = 0; vram_wr_addr = all 1s; vram_wr_data = 0.
- overflow = 0; stall_count = 0.
- Resulting outputs: cpu_wr_ready = 1, busy = 0.
REQ-031 After reset, vram_wr_ack is expected to be 0, matching the arbiter's reset value; no request is pending.

Configuration
REQ-032 Macro VRAM_WRQ_STATS_EN defined: stall_count increments on every cycle in WAIT with req != ack, saturates at 16'hFFFF, and is cleared by flush.
REQ-033 Macro VRAM_WRQ_STATS_EN undefined: stall_count is tied to 0, no counter logic is present, and all other behaviour is identical.

Structure
REQ-034 Package vdp_wrq_pkg holds:
- the state enum (IDLE, ISSUE, WAIT);
- the entry struct {addr, data};
- default DEPTH and ADDR_W localparams.
REQ-035 Sub-module vram_wrq_fifo (storage, pointers, count, full/empty); the FSM, handshake and statistics stay in the top module.

Verification
REQ-036 Single write, arbiter acks 3 cycles after the request:
- Stimulus: push addr=0x1_2345, data=0xA5 in an empty queue.
- Response: vram_wr_req toggles at N+2 with outputs 0x1_2345/0xA5; busy falls 1 cycle after the ack; stall_count=3 when VRAM_WRQ_STATS_EN is defined.
REQ-037 Fill and overflow, ack held back:
- Stimulus: 5 pushes of data 0x01..0x05 with DEPTH=4.
- Response: cpu_wr_ready=0 after the 4th entry is queued; 0x05 is dropped; overflow=1; only 4 writes are later issued.
REQ-038 Back-to-back issue, arbiter acks every cycle:
- Stimulus: 4 queued entries.
- Response: a toggle on consecutive ack edges, in push order; the queue empties with no IDLE gap.
REQ-039 Flush with an in-flight request:
- Stimulus: 3 queued entries, flush while WAIT.
- Response: the pending write completes; the other 2 are never issued; state returns to IDLE; overflow=0.
REQ-040 Reset mid-transfer:
- Stimulus: assert RESET in WAIT with 2 entries queued.
- Response: all outputs take their reset values asynchronously; after release, there is no toggle until a new push.
